// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the parity-extended memory controller.
package mem_ctrl_pkg;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int MEM_W = DW + 1;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

    // Stored parity bit is the XOR of the data bits.
    function automatic logic parity_of(input logic [DW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_parity_master.sv
// Initiator for the parity-extended memory: one request at a time, reads
// return data plus a parity-error flag on a valid/ready response channel.
module mem_parity_master #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_parity_err,
    output logic [15:0]   err_count,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW:0]   mem_data_out
);
    import mem_ctrl_pkg::*;

    state_t     state;
    logic [2:0] lat_cnt;
    logic       sample_err;

    assign sample_err = mem_data_out[DW] ^ parity_of(mem_data_out[DW-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_parity_err <= 1'b0;
            err_count      <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is low only in the first IDLE cycle after reset.
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready   <= 1'b0;
                        mem_address <= req_addr;
                        mem_data_in <= req_wdata;
                        if (req_write) begin
                            mem_write <= 1'b1;
                            state     <= WR;
                        end else begin
                            mem_read <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR: begin
                    mem_write <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                RD: begin
                    mem_read <= 1'b0;
                    lat_cnt  <= 3'(RD_LAT - 1);
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= mem_data_out[DW-1:0];
                        rsp_parity_err <= sample_err;
                        if (sample_err && (err_count != '1))
                            err_count <= err_count + 16'd1;
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_parity_master.sv
// Directed plus randomized checks of mem_parity_master against a
// behavioural memory and an expected-data table.
module tb_mem_parity_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [15:0] req_addr, err_count, mem_address;
    logic [7:0]  req_wdata, rsp_rdata, mem_data_in;
    logic        rsp_parity_err, mem_write, mem_read;
    logic [8:0]  mem_data_out;

    logic        rst3, req_valid3, req_ready3, rsp_valid3, rsp_parity_err3;
    logic        mem_write3, mem_read3;
    logic [15:0] err_count3, mem_address3;
    logic [7:0]  rsp_rdata3, mem_data_in3;
    logic [8:0]  mem_data_out3;

    mem_parity_master #(.AW(16), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_parity_err(rsp_parity_err), .err_count(err_count),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_parity_master #(.AW(16), .DW(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .rsp_parity_err(rsp_parity_err3), .err_count(err_count3),
        .mem_write(mem_write3), .mem_read(mem_read3), .mem_address(mem_address3),
        .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3)
    );

    // Behavioural memory: stores {^data, data}; corrupt flips the stored parity on readout.
    logic [8:0] mem_arr [0:65535];
    logic       corrupt;
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_address] <= {^mem_data_in, mem_data_in};
        if (mem_read)  mem_data_out <= mem_arr[mem_address] ^ {corrupt, 8'h00};
        if (mem_read3) mem_data_out3 <= 9'h100;
    end

    int cyc = 0, wr_pulses = 0, wr_run = 0, max_wr_run = 0, rd_cycles = 0;
    bit wr_prev = 1'b0, both_seen = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        wr_prev   <= mem_write;
        wr_pulses <= wr_pulses + ((mem_write && !wr_prev) ? 1 : 0);
        wr_run    <= mem_write ? wr_run + 1 : 0;
        if (mem_write && (wr_run + 1 > max_wr_run)) max_wr_run <= wr_run + 1;
        rd_cycles <= rd_cycles + (mem_read ? 1 : 0);
        if (mem_write && mem_read) both_seen <= 1'b1;
    end

    int          checks = 0, errors = 0;
    logic [7:0]  exp_data [0:65535];
    logic [15:0] exp_cnt = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        req_write = 1'b1; req_addr = a; req_wdata = d;
        wait_ready("wr");
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        exp_data[a] = d;
    endtask

    task automatic do_read(input logic [15:0] a, input bit bad, input int stall, input string tag);
        int n = 0;
        logic [7:0] ed;
        logic       ee;
        corrupt = bad; req_write = 1'b0; req_addr = a;
        wait_ready(tag);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        ed = exp_data[a];
        ee = bad;
        if (ee && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        check({tag, "_latency"}, n, 2);
        check({tag, "_rdata"}, rsp_rdata, ed);
        check({tag, "_perr"}, rsp_parity_err, ee);
        check({tag, "_errcnt"}, err_count, exp_cnt);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold"}, {rsp_valid, req_ready, rsp_rdata, rsp_parity_err},
                  {1'b1, 1'b0, ed, ee});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_release"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2, p0, r0, n, seen;
        logic [15:0] addrs [16];

        rst_n = 1'b0; rst3 = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; corrupt = 1'b0;
        repeat (2) tick();
        check("rst_outputs", {req_ready, rsp_valid, mem_write, mem_read, rsp_parity_err}, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_addr", mem_address, 0);
        rst_n = 1'b1; rst3 = 1'b1;
        tick();
        check("ready_after_rst", req_ready, 1);

        do_write(16'h1234, 8'hA5);
        do_read(16'h1234, 1'b0, 0, "rd_a5");

        // Back-to-back writes with req_valid held high.
        p0 = wr_pulses; r0 = rd_cycles;
        req_write = 1'b1; req_addr = 16'h0001; req_wdata = 8'h07;
        wait_ready("b2b");
        req_valid = 1'b1; t1 = cyc;
        tick();
        req_addr = 16'h0002; req_wdata = 8'hFF;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        t2 = cyc;
        tick();
        req_valid = 1'b0;
        exp_data[16'h0001] = 8'h07; exp_data[16'h0002] = 8'hFF;
        repeat (2) tick();
        check("b2b_spacing", t2 - t1, 2);
        check("b2b_pulses", wr_pulses - p0, 2);
        check("b2b_pulse_len", max_wr_run, 1);
        check("b2b_no_read", rd_cycles - r0, 0);
        do_read(16'h0001, 1'b0, 0, "rd_b2b1");
        do_read(16'h0002, 1'b0, 1, "rd_b2b2");

        do_write(16'h0050, 8'hA5);
        do_read(16'h0050, 1'b0, 0, "par_ok");
        do_read(16'h0050, 1'b1, 0, "par_bad");
        check("par_errcnt_one", err_count, 1);

        do_read(16'h1234, 1'b0, 5, "stall5");

        // Reset during RD_WAIT on the RD_LAT=3 instance.
        n = 0;
        while (!req_ready3 && n < 20) begin tick(); n++; end
        check("lat3_ready", req_ready3, 1);
        req_write = 1'b0; req_addr = 16'h00AA; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        tick();
        rst3 = 1'b0;
        tick();
        check("lat3_in_rst", {req_ready3, rsp_valid3, mem_read3, mem_write3}, 0);
        rst3 = 1'b1;
        tick();
        check("lat3_ready_after_rst", req_ready3, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid3 || mem_read3) seen++;
            tick();
        end
        check("lat3_no_rsp", seen, 0);
        check("lat3_errcnt", err_count3, 0);

        for (int i = 0; i < 16; i++) begin
            addrs[i] = 16'($urandom);
            do_write(addrs[i], 8'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            int j;
            j = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) do_write(addrs[j], 8'($urandom));
            else do_read(addrs[j], ($urandom_range(0, 3) == 0), $urandom_range(0, 3), "rnd");
        end

        wait_ready("sat");
        force dut.err_count = 16'hFFFE;
        #1;
        release dut.err_count;
        exp_cnt = 16'hFFFE;
        check("sat_preload", err_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) do_read(16'h0050, 1'b1, 0, "sat");
        check("sat_final", err_count, 16'hFFFF);

        check("never_both_strobes", both_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_parity_master.md
Name: mem_parity_master

Overview:
- Initiator-side controller for the 16-bit-address, 8-bit-data, parity-extended memory (my_mem).
- Accepts read/write requests on a valid/ready channel and drives the memory's write/read/address/data_in pins.
- Captures the 9-bit {parity, data} read word, checks parity and returns the data with an error flag on a valid/ready response channel.
- Sits between a test or DMA agent and the memory macro.

Parameters:
- AW, 16, address width.
- DW, 8, data width; the memory word is DW+1 bits.
- RD_LAT, 1, cycles from the mem_read cycle's closing edge to valid mem_data_out; legal range 1..7.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data; ignored for reads
- rsp_valid  out  1  read response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DW  read data, i.e. mem_data_out[DW-1:0]
- rsp_parity_err  out  1  stored parity bit mismatches the data
- err_count  out  16  saturating count of parity errors
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_address  out  AW  memory address
- mem_data_in  out  DW  memory write data
- mem_data_out  in  DW+1  memory read word {parity, data}

Behaviour:
- Reset, applied on a rising edge with rst_n=0:
  - all outputs 0, except req_ready, which is 0 during reset and 1 in the first cycle after it;
  - err_count is cleared to 0;
  - the FSM enters IDLE.
- Reset wins over any in-flight operation: pending reads are dropped with no response, and no mem strobe is issued in the following cycle.
- All outputs are registered.
- Handshake: a transfer occurs on an edge where valid & ready are both 1. req_ready=1 only in IDLE.
- FSM states:
  - IDLE: req_ready=1. On accept with write=1, go to WR; with write=0, go to RD. Address and data are latched into mem_address and mem_data_in.
  - WR: mem_write=1 for exactly one cycle, then IDLE. A write produces no response. Back-to-back writes therefore give one accept every 2 cycles.
  - RD: mem_read=1 for exactly one cycle, then RD_WAIT with the counter loaded to RD_LAT-1.
  - RD_WAIT: the counter decrements each cycle. When it reaches 0, mem_data_out is sampled on that edge and the FSM goes to RESP.
  - RESP:
    - rsp_valid=1; rsp_rdata and rsp_parity_err are held stable while rsp_ready=0;
    - on the edge where rsp_ready=1, go to IDLE and drop rsp_valid in the next cycle.
- Read latency with RD_LAT=1: accept at edge k, mem_read high in cycle k..k+1, sample at edge k+2, rsp_valid high from cycle k+2.
- mem_address and mem_data_in hold their last value outside strobe cycles. mem_write and mem_read are never both 1.
- Parity: rsp_parity_err = mem_data_out[DW] XOR (XOR-reduce of mem_data_out[DW-1:0]), i.e. the stored bit is the XOR of the data bits.
- err_count increments by 1 on the sample edge when a parity error is detected, and saturates at 16'hFFFF.
- Inputs are don't-care while not in IDLE; req_valid with req_ready=0 is simply stalled.

Decomposition:
- mem_ctrl_pkg holds:
  - localparams AW, DW and MEM_W = DW+1;
  - typedef enum logic [2:0] state_t {IDLE, WR, RD, RD_WAIT, RESP};
  - the function parity_of(data) returning the XOR-reduce.
- Single module; no sub-module. The parity check is one package function.

Test Plan:
- Write addr 16'h1234 data 8'hA5, then read 16'h1234 against a my_mem instance -> rsp_rdata=8'hA5, rsp_parity_err=0, rsp_valid rises 2 cycles after the read accept.
- Two back-to-back writes (16'h0001/8'h07, 16'h0002/8'hFF) with req_valid held high -> accepts 2 cycles apart, mem_write pulses are one cycle each, mem_read stays 0.
- Behavioural memory returns 9'h0A5 (parity 0 against data 8'hA5, whose XOR is 0), then 9'h1A5 -> first response err=0, second err=1, err_count=1.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0; after rsp_ready=1, req_ready=1 in the next cycle.
- rst_n=0 during RD_WAIT with RD_LAT=3 -> no rsp_valid, err_count=0, req_ready=1 in the first cycle after reset.
- Force err_count to 16'hFFFE and inject 3 bad-parity reads -> err_count saturates at 16'hFFFF.
